// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: reorder-buffer commit sequencer.
// Inspects the ROB head each cycle and retires it when allowed. A retirement
// pops the ROB, optionally writes the register file and bumps instret.
// Stores with a clear commit bit are handed to the LSQ and waited on.
// Taken branches and jumps retire, then flush the pipeline for FLUSH_HOLD
// cycles while presenting the redirect PC.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   head_*                     ROB head entry fields
//   dmem_work                  data memory busy (blocks branch/jump commits)
//   store_done                 LSQ pulse: head store completed
//   rob_pop                    retire head this cycle (combinational)
//   rf_we/rf_rd/rf_data/rf_tag register file write port
//   store_go                   permission for the LSQ to perform the head store
//   flush, redirect_pc         pipeline flush and fetch redirect target
//   instret                    retired instruction count
module rob_commit_ctrl #(
    parameter int unsigned FLUSH_HOLD = 1,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             head_valid,
    input  logic             head_commit,
    input  logic [6:0]       head_opcode,
    input  logic [4:0]       head_rds,
    input  logic [31:0]      head_val,
    input  logic             head_br_en,
    input  logic [31:0]      head_br_target,
    input  logic [TAG_W-1:0] head_tag,
    input  logic             dmem_work,
    input  logic             store_done,
    output logic             rob_pop,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [31:0]      rf_data,
    output logic [TAG_W-1:0] rf_tag,
    output logic             store_go,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [63:0]      instret
);

    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;

    typedef enum logic [1:0] {StRun, StStWait, StFlush} state_e;

    state_e      state_q;
    logic [31:0] cnt_q;

    logic is_store, is_br, is_jump, is_ctl, mispredict;

    always_comb begin
        is_store   = (head_opcode == OpStore);
        is_br      = (head_opcode == OpBr);
        is_jump    = (head_opcode == OpJal) || (head_opcode == OpJalr);
        is_ctl     = is_br || is_jump;
        // Branches are predicted not-taken, so every jump is a mispredict.
        mispredict = (is_br && head_br_en) || is_jump;

        // Gated by rst so nothing retires while reset is held.
        rob_pop = !rst && (state_q == StRun) && head_valid && head_commit
                  && !(is_ctl && dmem_work);
        rf_we   = rob_pop && (head_rds != 5'd0) && !is_store && !is_br;
        rf_rd   = head_rds;
        rf_data = head_val;
        rf_tag  = head_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            flush       <= 1'b0;
            store_go    <= 1'b0;
            redirect_pc <= 32'd0;
            instret     <= 64'd0;
            cnt_q       <= 32'd0;
        end else begin
            if (rob_pop) begin
                instret <= instret + 64'd1;
            end
            unique case (state_q)
                StRun: begin
                    if (rob_pop && mispredict) begin
                        state_q     <= StFlush;
                        flush       <= 1'b1;
                        redirect_pc <= head_br_target;
                        cnt_q       <= 32'(FLUSH_HOLD - 1);
                    end else if (head_valid && is_store && !head_commit) begin
                        state_q  <= StStWait;
                        store_go <= 1'b1;
                    end
                end
                StStWait: begin
                    // The ROB sets the commit bit on this same edge.
                    if (store_done) begin
                        state_q  <= StRun;
                        store_go <= 1'b0;
                    end
                end
                StFlush: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= StRun;
                        flush   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: begin
                    state_q  <= StRun;
                    flush    <= 1'b0;
                    store_go <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rob_commit_ctrl.md
# rob_commit_ctrl

Commit sequencer for the reorder buffer. Each cycle it inspects the ROB head entry and decides whether to retire it. Retiring an entry pops it, writes the register file and counts it. The block also hands stores at the head to the LSQ and waits for them to complete. On a taken branch or a jump it retires the entry, then drives a multi-cycle pipeline flush with the redirect PC. It sits between the ROB head outputs and the regfile, LSQ and fetch redirect logic.

## Interface
- `FLUSH_HOLD`, default 1: number of cycles `flush` stays high per redirect (≥1).
- `TAG_W`, default 4: ROB tag width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `head_valid` in 1: ROB is not empty.
- `head_commit` in 1: head entry commit bit is set.
- `head_opcode` in 7: head entry opcode.
- `head_rds` in 5: head entry destination register.
- `head_val` in 32: head entry result value.
- `head_br_en` in 1: head entry branch was resolved taken.
- `head_br_target` in 32: head entry resolved target.
- `head_tag` in TAG_W: ROB index of the head.
- `dmem_work` in 1: data memory is busy; while high, branch and jump commits are blocked.
- `store_done` in 1: one-cycle pulse from the LSQ meaning the head store has completed.
- `rob_pop` out 1: retire the head this cycle (drives the ROB `ready_`).
- `rf_we` out 1: register file write enable.
- `rf_rd` out 5: register file write address.
- `rf_data` out 32: register file write data.
- `rf_tag` out TAG_W: ROB tag of the write, used to clear the rename map.
- `store_go` out 1: permission for the LSQ to perform the head store.
- `flush` out 1: pipeline flush.
- `redirect_pc` out 32: fetch redirect target, valid while `flush` is high.
- `instret` out 64: count of retired instructions.

## Operation
- Opcode classes:
  - store = 7'b0100011
  - br = 7'b1100011
  - jal = 7'b1101111
  - jalr = 7'b1100111
- Branches are predicted not-taken. A mispredict means a br with `head_br_en`=1, or any jal or jalr.
- States: RUN, ST_WAIT, FLUSH.
- **RUN**
  - Commit condition: `head_valid` && `head_commit` && !(class∈{br,jal,jalr} && `dmem_work`).
  - When the commit condition holds, `rob_pop`=1, combinationally in the same cycle.
  - `rf_we` = pop && `head_rds`≠0 && class∉{store,br}.
  - `rf_rd`=`head_rds`, `rf_data`=`head_val` and `rf_tag`=`head_tag` are always driven; they are qualified by `rf_we`.
  - A mispredict pop → next state FLUSH. On the same edge `redirect_pc` is loaded with `head_br_target` and the flush counter is loaded with FLUSH_HOLD−1.
  - A head that is a store with `head_commit`=0 → next state ST_WAIT. No pop occurs that cycle.
- **ST_WAIT**
  - `store_go`=1 (registered: high from the cycle after entry), `rob_pop`=0.
  - `store_done` → next state RUN; `store_go` deasserts on the same edge.
  - The ROB sets the commit bit on that edge, so the store retires in RUN no earlier than the following cycle.
- **FLUSH**
  - `flush`=1 (registered, so it goes high the cycle after the mispredict pop); `rob_pop`=0; `store_go`=0.
  - The counter decrements each cycle. When it reaches 0, the next state is RUN.
- `instret` increments by 1 on every cycle with `rob_pop`=1 and wraps at 2^64.
- `redirect_pc` holds its value outside FLUSH.

## Timing
- Reset (asynchronous; outputs are forced immediately):
  - state=RUN; `flush`=0, `store_go`=0, `redirect_pc`=0, `instret`=0, flush counter=0.
  - `rob_pop`=0 and `rf_we`=0 while `rst` is high.
- Commit latency: at most 1 retirement per cycle. A head becomes retireable in the cycle its commit bit is visible, and `rob_pop` is asserted in that same cycle.
- Mispredict timing:
  - cycle N: pop.
  - cycles N+1 .. N+FLUSH_HOLD: `flush`=1.
  - cycle N+FLUSH_HOLD+1: RUN again, and a pop is allowed in that cycle.
- `head_valid`=0 in RUN: no pop and no state change, regardless of the other head fields.
- `store_done` while not in ST_WAIT: ignored.
- `dmem_work` high:
  - A committed branch stalls in RUN with no pop until `dmem_work` falls.
  - Non-branch heads are unaffected.
- `dmem_work` and `store_done` arriving together in ST_WAIT: go to RUN.
- `rst` asserted mid-ST_WAIT or mid-FLUSH: `store_go` and `flush` drop immediately, and the state is RUN on reset release.
- `head_tag` wrap-around (15→0) needs no special handling.

## Test plan
- Reset, then an add head (opcode 0110011, rds=5, val=0xDEADBEEF, commit=1) → `rob_pop`=1, `rf_we`=1, `rf_rd`=5, `rf_data`=0xDEADBEEF in the same cycle; `instret`=1 on the next cycle.
- Head with rds=0 and commit=1 → `rob_pop`=1, `rf_we`=0. Store head with commit=0 → `store_go`=1 from the next cycle. Then `store_done` pulse, then commit=1 → pop one cycle later, with `rf_we`=0.
- Taken branch head (br_en=1, target=0x6000_0040) with FLUSH_HOLD=2 → pop at N; `flush`=1 at N+1 and N+2 with `redirect_pc`=0x6000_0040; pop allowed again at N+3.
- Committed jal head with `dmem_work`=1 for 3 cycles → no pop for those 3 cycles; pop on the cycle `dmem_work`=0, followed by a flush.
- Not-taken branch → pop with no flush. 10 consecutive committed ALU heads → 10 pops in 10 cycles and `instret`=10.
- `rst` pulsed during ST_WAIT and during FLUSH → `store_go`=0 and `flush`=0 immediately, `instret`=0, and normal commit resumes after release.
